// File: rtl/rr_detect_sched.sv
// rtl/rr_detect_sched.sv - round-robin share of one "0-then-1" Mealy detector across N requesters
// Define FIXED_PRIO_EN to replace round-robin with lowest-index-wins arbitration.
module rr_detect_sched #(
  parameter int N     = 4,
  parameter int BURST = 8,
  parameter int CW    = 4,
  parameter int IDW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   ain,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           sel_ain,
  output logic           det,
  output logic [CW-1:0]  hit_cnt,
  output logic           done,
  output logic [IDW-1:0] done_id,
  output logic           aborted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0]    LP_LAST_BIT = 8'(BURST - 1);
  localparam logic [CW-1:0] LP_HIT_MAX  = {CW{1'b1}};
  localparam logic [N-1:0]  LP_ONE      = {{(N-1){1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_sel;
  logic [IDW-1:0] r_last;
  logic [7:0]     r_bitcnt;
  logic           r_dstate;
  logic [CW-1:0]  r_hit;
  logic [IDW-1:0] r_done_id;
  logic           r_aborted;

  logic           w_any;
  logic [IDW-1:0] w_pick;
  logic           w_req_sel;
  logic           w_sel_ain;
  logic           w_busy;
  logic           w_det;
  logic           w_last_bit;

  // Arbiter: the highest-priority candidate is written last so it wins.
  always_comb begin
    w_any  = |req;
    w_pick = '0;
`ifdef FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_pick = IDW'(i);
    end
`else
    for (int k = N; k >= 1; k--) begin
      int c;
      c = (int'(r_last) + k) % N;
      if (req[c]) w_pick = IDW'(c);
    end
`endif
  end

  always_comb begin
    w_busy     = (r_state == S_RUN);
    w_req_sel  = req[r_sel];
    w_sel_ain  = w_busy ? ain[r_sel] : 1'b0;
    w_det      = w_busy & r_dstate & w_sel_ain;
    w_last_bit = (r_bitcnt == LP_LAST_BIT);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_any) w_next = S_RUN;
      S_RUN:  if (!w_req_sel || w_last_bit) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_sel     <= '0;
      r_last    <= IDW'(N - 1);
      r_bitcnt  <= '0;
      r_dstate  <= 1'b0;
      r_hit     <= '0;
      r_done_id <= '0;
      r_aborted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt    <= LP_ONE << w_pick;
            r_sel    <= w_pick;
            r_bitcnt <= '0;
            r_hit    <= '0;
            r_dstate <= 1'b0;
          end
        end
        S_RUN: begin
          // A dropped request discards the bit sampled on the same edge.
          if (!w_req_sel) begin
            r_gnt     <= '0;
            r_aborted <= 1'b1;
            r_done_id <= r_sel;
          end else begin
            r_dstate <= ~w_sel_ain;
            r_bitcnt <= r_bitcnt + 8'd1;
            if (w_det && (r_hit != LP_HIT_MAX)) r_hit <= r_hit + 1'b1;
            if (w_last_bit) begin
              r_gnt     <= '0;
              r_aborted <= 1'b0;
              r_done_id <= r_sel;
            end
          end
        end
        S_DONE: r_last <= r_sel;
        default: ;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = w_busy;
  assign sel_ain = w_sel_ain;
  assign det     = w_det;
  assign hit_cnt = r_hit;
  assign done    = (r_state == S_DONE);
  assign done_id = r_done_id;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_rr_detect_sched.sv
// tb/tb_rr_detect_sched.sv - randomized bench for rr_detect_sched against a burst-level reference model
// Second instance with CW=2 shares all inputs to observe counter saturation.
module tb_rr_detect_sched;

  localparam int N     = 4;
  localparam int BURST = 8;
  localparam int IDW   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   ain;
  logic [N-1:0]   gnt;
  logic           busy, sel_ain, det, done, aborted;
  logic [3:0]     hit_cnt;
  logic [IDW-1:0] done_id;

  logic [N-1:0]   s_gnt;
  logic           s_busy, s_sel_ain, s_det, s_done, s_aborted;
  logic [1:0]     s_hit_cnt;
  logic [IDW-1:0] s_done_id;

  int n_chk  = 0;
  int n_fail = 0;
  int m_last = N - 1;

  always #5 clk = ~clk;

  rr_detect_sched #(.N(N), .BURST(BURST), .CW(4), .IDW(IDW)) u_dut (
    .clk(clk), .rst(rst), .req(req), .ain(ain), .gnt(gnt), .busy(busy),
    .sel_ain(sel_ain), .det(det), .hit_cnt(hit_cnt), .done(done),
    .done_id(done_id), .aborted(aborted)
  );

  rr_detect_sched #(.N(N), .BURST(BURST), .CW(2), .IDW(IDW)) u_dut_sat (
    .clk(clk), .rst(rst), .req(req), .ain(ain), .gnt(s_gnt), .busy(s_busy),
    .sel_ain(s_sel_ain), .det(s_det), .hit_cnt(s_hit_cnt), .done(s_done),
    .done_id(s_done_id), .aborted(s_aborted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int last);
`ifdef FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (m[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_det"}, det, 0);
    chk({tag, "_sel_ain"}, sel_ain, 0);
    chk({tag, "_hit"}, hit_cnt, 0);
    chk({tag, "_done_id"}, done_id, 0);
    chk({tag, "_aborted"}, aborted, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ain = '0;
    step();
    step();
    rst = 1'b0;
    m_last = N - 1;
    chk_idle_zero("reset");
  endtask

  // One burst: grant, BURST bits (or fewer on abort/reset), DONE cycle, return to IDLE.
  task automatic run_burst(input logic [N-1:0] mask, input logic [BURST-1:0] bits,
                           input int abort_at, input int rst_at);
    int idx, cnt;
    logic prev, b, was_abort;
    logic [N-1:0] oh;
    idx = pick(mask, m_last);
    oh  = N'(1) << idx;
    req = mask;
    ain = N'($urandom);
    step();
    chk("grant", gnt, oh);
    chk("busy_run", busy, 1);
    chk("hit_clear", hit_cnt, 0);
    cnt = 0;
    prev = 1'b1;
    was_abort = 1'b0;
    for (int j = 0; j < BURST; j++) begin
      b = bits[j];
      req = N'($urandom) | oh;
      ain = N'($urandom);
      ain[idx] = b;
      if (j == abort_at) req[idx] = 1'b0;
      if (j == rst_at) rst = 1'b1;
      #1;
      chk("sel_ain", sel_ain, b);
      chk("det", det, (j > 0) && !prev && b);
      step();
      if (j == rst_at) begin
        rst = 1'b0;
        req = '0;
        m_last = N - 1;
        chk_idle_zero("midrst");
        return;
      end
      if (j == abort_at) begin
        was_abort = 1'b1;
        break;
      end
      if ((j > 0) && !prev && b) cnt++;
      prev = b;
    end
    chk("done", done, 1);
    chk("done_id", done_id, idx);
    chk("aborted", aborted, was_abort);
    chk("hit_cnt", hit_cnt, sat(cnt, 15));
    chk("hit_cnt_sat", s_hit_cnt, sat(cnt, 3));
    chk("gnt_done", gnt, 0);
    chk("busy_done", busy, 0);
    req = was_abort ? (mask & ~oh) : mask;
    step();
    chk("done_clr", done, 0);
    chk("gnt_bubble", gnt, 0);
    chk("hit_hold", hit_cnt, sat(cnt, 15));
    chk("done_id_hold", done_id, idx);
    m_last = idx;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    ain = '0;
    do_reset();

    // Stream 0,1,0,1,1,0,0,1 on requester 1: hits on bits 1,3,7.
    run_burst(4'b0010, 8'h9A, -1, -1);

    // All requesting: order 0,1,2,3,0 after reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("rr_order", pick(4'b1111, m_last), i % N);
      run_burst(4'b1111, BURST'($urandom), -1, -1);
    end

    // Alternating stream: four detections saturate the CW=2 counter.
    run_burst(4'b0100, 8'hAA, -1, -1);

    // Abort after bits 0,1,1 on requester 0; requester 2 is next.
    do_reset();
    run_burst(4'b0101, 8'b0000_0110, 3, -1);
    run_burst(4'b0100, BURST'($urandom), -1, -1);

    // Reset at bit 4 kills the burst; arbitration restarts at requester 0.
    run_burst(4'b1111, BURST'($urandom), -1, 4);
    run_burst(4'b1111, BURST'($urandom), -1, -1);

    do_reset();
    run_burst(4'b1010, BURST'($urandom), -1, -1);
    run_burst(4'b1010, BURST'($urandom), -1, -1);

    for (int i = 0; i < 12; i++) begin
      int ab;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, BURST - 1)) : -1;
      run_burst(N'($urandom_range(1, 15)), BURST'($urandom), ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_detect_sched.md
Name: rr_detect_sched

Overview:
Round-robin scheduler that shares one serial "0-then-1" Mealy detector among N requesters. Each granted requester streams a fixed-length burst of bits through the shared detector, and the block counts detections per burst. It reports a done pulse with the requester id and hit count. It sits between the lab's input switches/stimulus channels and the display/result logic.

Parameters:
N, 4, number of requesters (2..8)
BURST, 8, bits per granted burst (2..255)
CW, 4, width of hit counter
IDW, 2, width of requester id (must be >= clog2(N))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req  in  N  per-requester request, level; hold high for whole burst
ain  in  N  per-requester serial data bit
gnt  out  N  one-hot grant, registered
busy  out  1  high while a burst is in progress (state RUN)
sel_ain  out  1  muxed data bit of granted requester (0 when no grant)
det  out  1  Mealy detect: granted bit is 1 and previous burst bit was 0
hit_cnt  out  CW  detections in current/last burst, saturating
done  out  1  one-cycle pulse at end of burst
done_id  out  IDW  index of requester whose burst ended, valid with done, held after
aborted  out  1  valid with done: burst ended early due to req drop

Behaviour:
- Reset values: gnt=0, busy=0, det=0, hit_cnt=0, done=0, done_id=0, aborted=0, state=IDLE, bitcnt=0, dstate=0, last=N-1 (so requester 0 has first priority).
- States: IDLE, RUN, DONE.
- IDLE: at an edge with any req bit high, pick the first set req scanning last+1, last+2, ... modulo N. Set gnt to that one-hot, sel register=idx, bitcnt=0, hit_cnt=0, dstate=0, go RUN. No req: stay IDLE.
- Latency: req high before edge k gives gnt high from edge k. The first burst bit is sampled at edge k+1.
- RUN: sel_ain=ain[sel] combinationally. det = busy & dstate & sel_ain (Mealy, combinational).
- RUN, at each edge: dstate <= ~sel_ain; bitcnt++; if det, hit_cnt++, saturating at 2^CW-1.
- RUN exit on the edge sampling bit BURST-1 (bitcnt==BURST-1): go DONE, aborted<=0.
- RUN abort: if req[sel]==0 at an edge in RUN, that bit is discarded (no count, no dstate update). Go DONE with aborted<=1.
- Abort has priority over the normal final-bit completion at the same edge.
- DONE (exactly one cycle): done=1, done_id=sel, gnt=0, busy=0, last<=sel, then IDLE. hit_cnt and done_id hold until the next grant.
- A new request is never granted in the DONE cycle. Back-to-back bursts therefore have one idle bubble minimum (DONE then IDLE-grant edge).
- Requests from non-granted requesters during RUN are ignored and do not preempt.
- Saturation: hit_cnt stays at 2^CW-1; no wrap.
- rst high at any edge (including mid-RUN): all registers return to reset values immediately. No done pulse is produced for the killed burst.
- The first bit of a burst can never assert det (dstate cleared at grant).

Optional Feature:
FIXED_PRIO_EN. Defined: arbitration always picks the lowest-index set req, and last is unused. Undefined: round-robin as above. The default build has it undefined.

Test Plan:
- Reset, then req=4'b0010, ain[1] stream 0,1,0,1,1,0,0,1 -> gnt=0010 one edge after req; det pulses on bits 1,3,7; done after 8 bits with done_id=1, hit_cnt=3, aborted=0.
- req=4'b1111 held through 4 bursts after reset -> grant order 0,1,2,3, then 0 again; exactly one DONE bubble cycle between bursts.
- CW=2 with stream 0,1,0,1,0,1,0,1 on requester 2 -> hit_cnt saturates at 3 (4 detections); done_id=2.
- Requester 0 granted; drop req[0] after 3 bits (bits 0,1,1) -> done pulse, aborted=1, hit_cnt=1, done_id=0; next grant goes to the next pending requester.
- rst asserted for 1 cycle at bit 4 of a burst -> all outputs 0 next cycle, no done pulse; next grant starts at requester 0.
- With FIXED_PRIO_EN, req=4'b1010 held for 2 bursts -> both grants go to requester 1.
